// File: rtl/io_pin_conditioner.sv
// io_pin_conditioner: conditions raw asynchronous pad inputs for the io filter.
// Each pin passes through a 2-flop synchronizer and then a run-time programmable
// stability counter. A new level is adopted only after it has been stable for
// db_limit+1 cycles. Output-direction pins are forced low.
// Optional feature macro: IO_COND_CHANGE_LATCH_EN adds sticky per-pin change
// flags with per-pin clear strobes. When the macro is undefined, change_flags
// is tied to zero and change_clr is ignored.
module io_pin_conditioner #(
    parameter int PINS = 16,
    parameter int DB_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PINS-1:0] pin_dir,
    input  logic [PINS-1:0] pad_in,
    input  logic [DB_W-1:0] db_limit,
    output logic [PINS-1:0] pin_data_out,
    output logic [PINS-1:0] change_flags,
    input  logic [PINS-1:0] change_clr
);

    logic [PINS-1:0] sync1_r;
    logic [PINS-1:0] sync2_r;
    logic [PINS-1:0] filt_r;
    logic [DB_W-1:0] cnt_r     [PINS];

    logic [PINS-1:0] filt_nxt_s;
    logic [DB_W-1:0] cnt_nxt_s [PINS];
    logic [PINS-1:0] chg_set_s;

    // Two-flop synchronizer on every pad, independent of pin direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= {PINS{1'b0}};
            sync2_r <= {PINS{1'b0}};
        end else begin
            sync1_r <= pad_in;
            sync2_r <= sync1_r;
        end
    end

    // Per-pin debounce next-state: force output pins low, otherwise count stability.
    always_comb begin
        for (int i = 0; i < PINS; i++) begin
            filt_nxt_s[i] = filt_r[i];
            cnt_nxt_s[i]  = cnt_r[i];
            chg_set_s[i]  = 1'b0;
            if (pin_dir[i]) begin
                filt_nxt_s[i] = 1'b0;
                cnt_nxt_s[i]  = {DB_W{1'b0}};
            end else if (sync2_r[i] == filt_r[i]) begin
                // Level matches the committed value: cancel any pending change.
                cnt_nxt_s[i]  = {DB_W{1'b0}};
            end else if (cnt_r[i] >= db_limit) begin
                // Stable long enough (live limit, so a lowered limit commits at once).
                filt_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]  = {DB_W{1'b0}};
                chg_set_s[i]  = 1'b1;
            end else begin
                // cnt stops at db_limit, so this increment never wraps.
                cnt_nxt_s[i]  = cnt_r[i] + DB_W'(1);
            end
        end
    end

    // Debounce state registers; reset aborts any count in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_r <= {PINS{1'b0}};
            for (int i = 0; i < PINS; i++) begin
                cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            filt_r <= filt_nxt_s;
            for (int i = 0; i < PINS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign pin_data_out = filt_r;

`ifdef IO_COND_CHANGE_LATCH_EN
    logic [PINS-1:0] flags_r;

    // Sticky change flags: a commit of a new level sets, strobe clears, set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_r <= {PINS{1'b0}};
        end else begin
            flags_r <= (flags_r & ~change_clr) | chg_set_s;
        end
    end

    assign change_flags = flags_r;
`else
    logic unused_flag_inputs_s;

    assign change_flags         = {PINS{1'b0}};
    assign unused_flag_inputs_s = ^{change_clr, chg_set_s};
`endif

endmodule

// File: tb/tb_io_pin_conditioner.sv
// Directed self-checking bench for io_pin_conditioner (PINS=16, DB_W=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_io_pin_conditioner;

    logic        clk;
    logic        rst_n;
    logic [15:0] pin_dir;
    logic [15:0] pad_in;
    logic [3:0]  db_limit;
    logic [15:0] pin_data_out;
    logic [15:0] change_flags;
    logic [15:0] change_clr;

    int checks;
    int fails;

    io_pin_conditioner #(.PINS(16), .DB_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin_dir      (pin_dir),
        .pad_in       (pad_in),
        .db_limit     (db_limit),
        .pin_data_out (pin_data_out),
        .change_flags (change_flags),
        .change_clr   (change_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        pin_dir    = 16'h0000;
        pad_in     = 16'hFFFF;
        db_limit   = 4'd0;
        change_clr = 16'h0000;

        // Reset holds everything low even with pads high.
        tick(3);
        check("reset_out", 32'(pin_data_out), 32'h0);
        check("reset_flags", 32'(change_flags), 32'h0);

        // Release: db_limit=0 -> output follows 3 edges after release.
        rst_n = 1'b1;
        tick(2);
        check("release_2", 32'(pin_data_out), 32'h0);
        tick(1);
        check("release_3", 32'(pin_data_out), 32'hFFFF);

        // Settle all pads low with db_limit=4 (2 + 5 cycles).
        pad_in   = 16'h0000;
        db_limit = 4'd4;
        tick(10);
        check("settle_low", 32'(pin_data_out), 32'h0);

        // Debounce latency on pin 3: rises at T+7, not at T+6.
        pad_in[3] = 1'b1;
        tick(6);
        check("latency_t6", 32'(pin_data_out[3]), 32'h0);
        tick(1);
        check("latency_t7", 32'(pin_data_out[3]), 32'h1);

        // 4-cycle pulse on pin 5 is rejected and the counter returns to 0.
        pad_in[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check("glitch4_out", 32'(pin_data_out[5]), 32'h0);
            if (k == 4) pad_in[5] = 1'b0;
        end
        check("glitch4_cnt", 32'(dut.cnt_r[5]), 32'h0);

        // 5-cycle pulse on pin 5 passes: high after edges 7..11.
        pad_in[5] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            check("pulse5_out", 32'(pin_data_out[5]), ((k >= 7) && (k <= 11)) ? 32'h1 : 32'h0);
            if (k == 5) pad_in[5] = 1'b0;
        end

        // Output-direction pin 7 stays low with pad high.
        pin_dir[7] = 1'b1;
        pad_in[7]  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("dir_out_low", 32'(pin_data_out[7]), 32'h0);
        end
        // Back to input with db_limit=2: rises after 3 cycles.
        pin_dir[7] = 1'b0;
        db_limit   = 4'd2;
        tick(2);
        check("dir_in_2", 32'(pin_data_out[7]), 32'h0);
        tick(1);
        check("dir_in_3", 32'(pin_data_out[7]), 32'h1);
        check("other_pin3", 32'(pin_data_out[3]), 32'h1);
        // Back to output: falls on the next cycle.
        pin_dir[7] = 1'b1;
        tick(1);
        check("dir_out_fall", 32'(pin_data_out[7]), 32'h0);

        // Limit lowered mid-count on pin 9: commit on the following edge.
        db_limit  = 4'd10;
        pad_in[9] = 1'b1;
        tick(8);
        check("limchg_cnt6", 32'(dut.cnt_r[9]), 32'h6);
        check("limchg_pre", 32'(pin_data_out[9]), 32'h0);
        db_limit = 4'd3;
        tick(1);
        check("limchg_commit", 32'(pin_data_out[9]), 32'h1);
        check("limchg_cnt0", 32'(dut.cnt_r[9]), 32'h0);

        // Max limit 15 on pin 11: needs 16 stable cycles (commit at edge 18).
        db_limit   = 4'd15;
        pad_in[11] = 1'b1;
        tick(17);
        check("maxlim_17", 32'(pin_data_out[11]), 32'h0);
        check("maxlim_cnt", 32'(dut.cnt_r[11]), 32'hF);
        tick(1);
        check("maxlim_18", 32'(pin_data_out[11]), 32'h1);

`ifdef IO_COND_CHANGE_LATCH_EN
        // Clear whatever earlier activity on pin 2 left behind.
        db_limit      = 4'd0;
        change_clr[2] = 1'b1;
        tick(1);
        change_clr[2] = 1'b0;
        check("flag_cleared", 32'(change_flags[2]), 32'h0);
        // A filtered rising edge sets the flag and it holds.
        pad_in[2] = 1'b1;
        tick(3);
        check("flag_set_out", 32'(pin_data_out[2]), 32'h1);
        check("flag_set", 32'(change_flags[2]), 32'h1);
        tick(4);
        check("flag_hold", 32'(change_flags[2]), 32'h1);
        change_clr[2] = 1'b1;
        tick(1);
        change_clr[2] = 1'b0;
        check("flag_clr", 32'(change_flags[2]), 32'h0);
        // Clear strobe coincident with a new commit: set wins.
        pad_in[2] = 1'b0;
        tick(2);
        change_clr[2] = 1'b1;
        tick(1);
        change_clr[2] = 1'b0;
        check("flag_setwins_out", 32'(pin_data_out[2]), 32'h0);
        check("flag_setwins", 32'(change_flags[2]), 32'h1);
`else
        // Without the feature the flags stay at zero regardless of activity.
        change_clr = 16'hFFFF;
        pad_in[2]  = 1'b1;
        tick(6);
        change_clr = 16'h0000;
        check("flags_tied", 32'(change_flags), 32'h0);
`endif

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/io_pin_conditioner.md
Name: io_pin_conditioner

Overview:
- Sits directly upstream of the io filter: takes raw asynchronous chip pad inputs and produces clean, synchronized, debounced pin levels that drive the io filter's pin_data_in.
- The io filter raises a mesh port event on every pin change, so glitches and metastable samples must be removed here.
- Per pin: a 2-flop synchronizer, then a run-time programmable stability counter. Output-direction pins are forced low.

Parameters:
- PINS, 16, number of io pins; must match the io filter pin count.
- DB_W, 4, width of the debounce counter and of db_limit.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- pin_dir  input  PINS  0=input, 1=output; same vector the io filter receives
- pad_in  input  PINS  raw asynchronous pad levels
- db_limit  input  DB_W  required stability length minus one, in cycles; 0 = minimum filtering
- pin_data_out  output  PINS  conditioned levels, to the io filter's pin_data_in
- change_flags  output  PINS  sticky per-pin change flags (optional feature)
- change_clr  input  PINS  per-pin flag clear strobes (optional feature)

Behaviour:
- Reset (rst_n=0 at posedge clk): sync1, sync2, filt, cnt and change_flags all 0, so pin_data_out=0. Reset has priority over everything and aborts any count in progress.
- Synchronizer: sync1<=pad_in; sync2<=sync1, for all pins regardless of direction.
- pin_data_out = filt, taken directly from a register with no combinational path from inputs.
- Per pin i, when pin_dir[i]=1 (output):
  - filt[i]<=0 and cnt[i]<=0 every cycle.
  - The io filter therefore never sees activity on output pins.
- Per pin i, when pin_dir[i]=0 (input), evaluated in priority order each cycle:
  - sync2[i]==filt[i]: cnt[i]<=0 (any pending change is cancelled).
  - else if cnt[i]>=db_limit: filt[i]<=sync2[i], cnt[i]<=0.
  - else: cnt[i]<=cnt[i]+1.
  - cnt never exceeds db_limit, so it cannot wrap.
- Timing consequences:
  - A new level must be held in sync2 for db_limit+1 consecutive cycles before filt adopts it.
  - Latency from a pad edge to pin_data_out: 2 cycles synchronizer + (db_limit+1) cycles filter.
  - Any pulse shorter than db_limit+1 cycles at sync2 is discarded entirely.
- Boundary cases:
  - db_limit changes mid-count: the live value is used. The >= comparison means lowering the limit below the current cnt commits on the next cycle.
  - db_limit=all-ones: 2^DB_W cycles of stability are required. cnt saturates exactly at the limit, so there is no overflow.
  - pin_dir 1->0: the pin starts from filt=0, cnt=0. If the pad is high, pin_data_out rises after db_limit+1 cycles of sync2 high, giving exactly one change event downstream.
  - pin_dir 0->1: filt is cleared next cycle. A pin that was high produces one falling event at the io filter; this is intended.
- Pins are fully independent; there is no cross-pin interaction.

Optional Feature:
- Macro: IO_COND_CHANGE_LATCH_EN.
- With the macro defined:
  - change_flags[i] is set on any cycle in which filt[i] is written with a different value (input pins only; forced clears on output pins do not set it).
  - change_flags[i] is cleared when change_clr[i]=1.
  - A set and a clear in the same cycle: set wins.
  - change_flags resets to 0.
  - Software or debug logic uses the flags to detect events missed between polls.
- Without the macro: change_flags is tied to 0, change_clr is ignored, and no flag registers are synthesized. Ports remain so instantiations are identical.

Test Plan:
- Reset/basic: rst_n=0 with pad_in=16'hFFFF for 3 cycles -> pin_data_out=0. Release with db_limit=0 and pin_dir=0 -> pin_data_out=16'hFFFF exactly 3 cycles after the first non-reset edge.
- Debounce latency: db_limit=4, pad_in[3] rises at cycle T -> pin_data_out[3] rises at T+2+5=T+7 and not earlier.
- Glitch rejection: db_limit=4, pad_in[5] high for 4 cycles then low -> pin_data_out[5] stays 0 and cnt[5] returns to 0. Repeat with a 5-cycle pulse -> output pulses high.
- Direction: pin_dir[7]=1 with pad_in[7]=1 -> pin_data_out[7]=0 permanently. Switch pin_dir[7]->0 with db_limit=2 -> output rises 3 cycles later. Switch back -> output falls next cycle.
- Limit change mid-count: db_limit=10, pad toggled and held; after cnt reaches 6, set db_limit=3 -> filt commits on the following cycle.
- Optional (IO_COND_CHANGE_LATCH_EN): a filtered edge on pin 2 sets change_flags[2]=1. It holds until change_clr[2] pulses. A clear pulsed in the same cycle as a new edge leaves the flag at 1.
